// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory read at a time, delivers each
// fetched word into the instruction queue, and predicts the next fetch PC
// with a direct-mapped BTB of 2-bit saturating counters.
//
// Handshake: MC_req/MC_addr form a request that stays asserted and stable
// until MC_done pulses for one cycle with MC_inst; IF_flag is a one-cycle push
// into the queue (no back-pressure on the push itself, IQ_full only gates the
// issue of the next request). rdy=0 freezes every register, including the BTB.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BTB_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        roll,
  input  logic [31:0] roll_PC,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_inst,
  input  logic        IQ_full,
  output logic        IF_flag,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_BTB_PC,
  output logic        IF_BTB_predict,
  input  logic        upd_flag,
  input  logic [31:0] upd_PC,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [1:0]  fsm_state
);

  localparam int ENTRIES = 1 << BTB_BITS;
  localparam int TAG_W   = 30 - BTB_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req_n;
  logic [31:0] addr_n;
  logic        flag_n;
  logic [31:0] inst_n, ifpc_n, btbpc_n;
  logic        pred_n;

  // BTB storage
  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [31:0]       btb_target [ENTRIES];
  logic [1:0]        btb_cnt    [ENTRIES];

  // Lookup side (current PC) and update side (resolved branch)
  logic [BTB_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                btb_hit, up_hit;
  logic [31:0]         pc_plus4, pred_next;

  // Word-offset bits never participate in indexing or tags
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_PC[1:0]};

  assign fsm_state = state;

  // BTB lookup reads the array before any same-cycle update lands
  always_comb begin
    lk_idx    = pc[BTB_BITS+1:2];
    lk_tag    = pc[31:BTB_BITS+2];
    up_idx    = upd_PC[BTB_BITS+1:2];
    up_tag    = upd_PC[31:BTB_BITS+2];
    btb_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag) && btb_cnt[lk_idx][1];
    up_hit    = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    pc_plus4  = pc + 32'd4;
    pred_next = btb_hit ? btb_target[lk_idx] : pc_plus4;
  end

  // Next-state and next-output logic for the fetch FSM
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = MC_req;
    addr_n  = MC_addr;
    flag_n  = 1'b0;
    inst_n  = IF_inst;
    ifpc_n  = IF_PC;
    btbpc_n = IF_BTB_PC;
    pred_n  = IF_BTB_predict;
    case (state)
      IDLE: begin
        req_n = 1'b0;
        if (roll) begin
          pc_n = roll_PC;
        end else if (!IQ_full) begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (roll) begin
          // Flush: a word arriving this edge is dropped, otherwise wait it out
          pc_n    = roll_PC;
          req_n   = 1'b0;
          state_n = MC_done ? IDLE : DRAIN;
        end else if (MC_done) begin
          flag_n  = 1'b1;
          inst_n  = MC_inst;
          ifpc_n  = pc;
          btbpc_n = pred_next;
          pred_n  = btb_hit;
          pc_n    = pred_next;
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      DRAIN: begin
        req_n = 1'b0;
        if (roll) pc_n = roll_PC;
        if (MC_done) state_n = IDLE;
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Fetch state and output registers, frozen while rdy is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      MC_req         <= 1'b0;
      MC_addr        <= 32'h0;
      IF_flag        <= 1'b0;
      IF_inst        <= 32'h0;
      IF_PC          <= 32'h0;
      IF_BTB_PC      <= 32'h0;
      IF_BTB_predict <= 1'b0;
    end else if (rdy) begin
      state          <= state_n;
      pc             <= pc_n;
      MC_req         <= req_n;
      MC_addr        <= addr_n;
      IF_flag        <= flag_n;
      IF_inst        <= inst_n;
      IF_PC          <= ifpc_n;
      IF_BTB_PC      <= btbpc_n;
      IF_BTB_predict <= pred_n;
    end
  end

  // BTB valid bits and counters: train on hit, allocate on taken miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cnt[i]   <= 2'd1;
      end
    end else if (rdy && upd_flag) begin
      if (up_hit) begin
        if (upd_taken && (btb_cnt[up_idx] != 2'd3))
          btb_cnt[up_idx] <= btb_cnt[up_idx] + 2'd1;
        else if (!upd_taken && (btb_cnt[up_idx] != 2'd0))
          btb_cnt[up_idx] <= btb_cnt[up_idx] - 2'd1;
      end else if (upd_taken) begin
        btb_valid[up_idx] <= 1'b1;
        btb_cnt[up_idx]   <= 2'd2;
      end
    end
  end

  // BTB tags and targets: only meaningful behind a valid bit, so no reset
  always_ff @(posedge clk) begin
    if (rdy && upd_flag && upd_taken) begin
      btb_target[up_idx] <= upd_target;
      if (!up_hit) btb_tag[up_idx] <= up_tag;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a fixed-latency memory model, an address queue and a
// delivery queue filled as each scenario is set up, and monitors that pop and
// compare whenever the DUT issues a request or pushes an instruction.
module tb_fetch_unit;

  localparam int LAT = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rdy = 1'b1, roll = 1'b0, iq_full = 1'b1;
  logic [31:0] roll_pc = '0;
  logic        mc_req, mc_done = 1'b0;
  logic [31:0] mc_addr, mc_inst = '0;
  logic        if_flag, if_btb_predict;
  logic [31:0] if_inst, if_pc, if_btb_pc;
  logic        upd_flag = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [1:0]  fsm_state;

  fetch_unit #(.RESET_PC(32'h0), .BTB_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .roll(roll), .roll_PC(roll_pc),
    .MC_req(mc_req), .MC_addr(mc_addr), .MC_done(mc_done), .MC_inst(mc_inst),
    .IQ_full(iq_full), .IF_flag(if_flag), .IF_inst(if_inst), .IF_PC(if_pc),
    .IF_BTB_PC(if_btb_pc), .IF_BTB_predict(if_btb_predict),
    .upd_flag(upd_flag), .upd_PC(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .fsm_state(fsm_state)
  );

  // scoreboard state
  logic [31:0] addr_q[$];
  logic [96:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dlv_count = 0;
  int last_dlv  = -1;
  bit gap_on    = 1'b0;
  bit en_last   = 1'b0;
  bit req_prev  = 1'b0;
  logic [31:0] model_pc = 32'h0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_c3c3;
  endfunction

  // memory model: one outstanding read, answers LAT cycles after the request
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  always @(negedge clk) begin
    mc_done = 1'b0;
    if (mem_pending) begin
      mem_cnt++;
      if (mem_cnt >= LAT) begin
        mc_done     = 1'b1;
        mc_inst     = inst_of(mem_addr);
        mem_pending = 1'b0;
      end
    end else if (mc_req) begin
      mem_pending = 1'b1;
      mem_cnt     = 1;
      mem_addr    = mc_addr;
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_last <= rdy && !rst;
  end

  // monitors: new requests against addr_q, queue pushes against exp_q
  always @(negedge clk) begin
    if (!rst) begin
      if (mc_req && !req_prev) begin
        if (addr_q.size() == 0) check_eq("unexpected_req", {96'h0, mc_req}, 128'h0);
        else check_eq("mc_addr", {96'h0, mc_addr}, {96'h0, addr_q.pop_front()});
      end
      if (if_flag && en_last) begin
        if (exp_q.size() == 0) check_eq("unexpected_if_flag", {96'h0, if_flag}, 128'h0);
        else check_eq("delivery{pc,inst,btb_pc,pred}",
                      {31'h0, if_pc, if_inst, if_btb_pc, if_btb_predict},
                      {31'h0, exp_q.pop_front()});
        if (gap_on && last_dlv >= 0) check_eq("fetch_period", cyc - last_dlv, LAT + 1);
        last_dlv = cyc;
        dlv_count++;
      end
    end
    req_prev = mc_req;
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(model_pc);
      exp_q.push_back({model_pc, inst_of(model_pc), model_pc + 32'd4, 1'b0});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic push_dlv(input logic [31:0] pc, input logic [31:0] nxt, input logic pred);
    addr_q.push_back(pc);
    exp_q.push_back({pc, inst_of(pc), nxt, pred});
  endtask

  task automatic wait_deliveries(input int n, input bit freeze);
    int start, budget;
    start = dlv_count;
    budget = 0;
    while ((dlv_count - start) < n && budget < 100 * n) begin
      step();
      budget++;
    end
    check_eq("deliveries", dlv_count - start, n);
    iq_full = 1'b1;
    if (freeze) rdy = 1'b0;
  endtask

  task automatic roll_idle(input logic [31:0] target);
    step();
    roll = 1'b1;
    roll_pc = target;
    step();
    roll = 1'b0;
  endtask

  task automatic btb_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    step();
    upd_flag = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = taken;
    step();
    upd_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fpc;
    // reset values
    #12;
    check_eq("rst_mc_req", mc_req, 0);
    check_eq("rst_mc_addr", mc_addr, 0);
    check_eq("rst_if_flag", if_flag, 0);
    check_eq("rst_if_inst", if_inst, 0);
    check_eq("rst_if_pc", if_pc, 0);
    check_eq("rst_if_btb_pc", if_btb_pc, 0);
    check_eq("rst_predict", if_btb_predict, 0);
    check_eq("rst_state", fsm_state, 0);
    step();
    rst = 1'b0;
    step();

    // straight-line fetch 0, 4, 8 at one instruction per LAT+1 cycles
    push_seq(3);
    gap_on = 1'b1;
    last_dlv = -1;
    iq_full = 1'b0;
    wait_deliveries(3, 1'b0);
    gap_on = 1'b0;

    // queue full for 10 cycles, then issue on the edge after it clears
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("iq_full_no_req", mc_req, 0);
    end
    push_seq(1);
    iq_full = 1'b0;
    step();
    check_eq("req_after_iq_full", mc_req, 1);
    check_eq("addr_after_iq_full", mc_addr, 32'hc);
    wait_deliveries(1, 1'b0);

    // roll two cycles into BUSY -> DRAIN, late word dropped
    addr_q.push_back(model_pc);
    iq_full = 1'b0;
    step();
    step();
    roll = 1'b1; roll_pc = 32'h100; iq_full = 1'b1;
    step();
    roll = 1'b0;
    check_eq("drain_state", fsm_state, 2);
    check_eq("drain_mc_req", mc_req, 0);
    step();
    check_eq("drain_done_state", fsm_state, 0);
    check_eq("drain_no_flag", if_flag, 0);
    model_pc = 32'h100;
    push_seq(1);
    iq_full = 1'b0;
    wait_deliveries(1, 1'b0);

    // roll on the same edge as MC_done
    addr_q.push_back(model_pc);
    iq_full = 1'b0;
    step();
    iq_full = 1'b1;
    step();
    step();
    roll = 1'b1; roll_pc = 32'h200;
    step();
    roll = 1'b0;
    check_eq("roll_done_no_flag", if_flag, 0);
    check_eq("roll_done_state", fsm_state, 0);
    check_eq("roll_done_mc_req", mc_req, 0);
    model_pc = 32'h200;
    push_seq(2);
    iq_full = 1'b0;
    wait_deliveries(2, 1'b0);

    // roll in IDLE suppresses the request that edge
    model_pc = 32'h300;
    push_seq(1);
    step();
    iq_full = 1'b0; roll = 1'b1; roll_pc = 32'h300;
    step();
    roll = 1'b0;
    check_eq("roll_idle_no_req", mc_req, 0);
    wait_deliveries(1, 1'b0);

    // BTB: allocate taken branch at 0x8 -> 0x40
    btb_update(32'h8, 32'h40, 1'b1);
    roll_idle(32'h8);
    push_dlv(32'h8, 32'h40, 1'b1);
    push_dlv(32'h40, 32'h44, 1'b0);
    iq_full = 1'b0;
    wait_deliveries(2, 1'b0);
    // two not-taken updates: counter 2 -> 0
    btb_update(32'h8, 32'h0, 1'b0);
    btb_update(32'h8, 32'h0, 1'b0);
    roll_idle(32'h8);
    push_dlv(32'h8, 32'hc, 1'b0);
    iq_full = 1'b0;
    wait_deliveries(1, 1'b0);
    // one taken update on a hit: counter 0 -> 1, still not predicted
    btb_update(32'h8, 32'h80, 1'b1);
    roll_idle(32'h8);
    push_dlv(32'h8, 32'hc, 1'b0);
    iq_full = 1'b0;
    wait_deliveries(1, 1'b0);
    // second taken: counter 2, predicted to the overwritten target
    btb_update(32'h8, 32'h80, 1'b1);
    roll_idle(32'h8);
    push_dlv(32'h8, 32'h80, 1'b1);
    push_dlv(32'h80, 32'h84, 1'b0);
    iq_full = 1'b0;
    wait_deliveries(2, 1'b0);
    model_pc = 32'h84;

    // rdy low for 5 cycles while IF_flag is high
    fpc = model_pc;
    push_seq(1);
    iq_full = 1'b0;
    wait_deliveries(1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("frz_if_flag", if_flag, 1);
      check_eq("frz_if_pc", if_pc, fpc);
      check_eq("frz_if_inst", if_inst, inst_of(fpc));
      check_eq("frz_if_btb_pc", if_btb_pc, fpc + 32'd4);
      check_eq("frz_mc_req", mc_req, 0);
    end
    rdy = 1'b1;
    step();
    check_eq("unfreeze_flag_low", if_flag, 0);

    // reset in the middle of BUSY; the stale MC_done must be ignored
    addr_q.push_back(model_pc);
    iq_full = 1'b0;
    step();
    iq_full = 1'b1;
    step();
    rst = 1'b1;
    #1;
    check_eq("midrst_mc_req", mc_req, 0);
    check_eq("midrst_state", fsm_state, 0);
    check_eq("midrst_mc_addr", mc_addr, 0);
    #1;
    rst = 1'b0;
    step();
    step();
    check_eq("stale_done_no_flag", if_flag, 0);
    check_eq("stale_done_state", fsm_state, 0);
    check_eq("stale_done_mc_req", mc_req, 0);
    // restart from RESET_PC with a cleared BTB (0x8 must not predict)
    model_pc = 32'h0;
    push_seq(3);
    iq_full = 1'b0;
    wait_deliveries(3, 1'b0);

    step();
    check_eq("addr_q_empty", addr_q.size(), 0);
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the first fetch address after reset.
REQ-002 SHALL have parameter BTB_BITS, default 4, the BTB index width (2**BTB_BITS entries).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy  in  1  low = freeze every register.
REQ-006 SHALL have port roll  in  1  misprediction flush; redirect to roll_PC.
REQ-007 SHALL have port roll_PC  in  32  redirect target.
REQ-008 SHALL have port MC_req  out  1  instruction-read request to the memory controller.
REQ-009 SHALL have port MC_addr  out  32  request address.
REQ-010 SHALL have port MC_done  in  1  one-cycle pulse; read complete.
REQ-011 SHALL have port MC_inst  in  32  fetched word, valid with MC_done.
REQ-012 SHALL have port IQ_full  in  1  instruction queue cannot accept.
REQ-013 SHALL have port IF_flag  out  1  one-cycle push into the instruction queue.
REQ-014 SHALL have ports IF_inst, IF_PC, IF_BTB_PC  out  32 each  instruction word, its PC, its predicted next PC.
REQ-015 SHALL have port IF_BTB_predict  out  1  1 = predicted taken.
REQ-016 SHALL have ports upd_flag (in 1), upd_PC (in 32), upd_target (in 32), upd_taken (in 1)  resolved-branch BTB update.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DRAIN, with at most one memory read outstanding.
REQ-018 IDLE: if !roll and !IQ_full, SHALL set MC_req=1, MC_addr=PC and go to BUSY; otherwise stay in IDLE with MC_req=0.
REQ-019 BUSY: SHALL hold MC_req=1 and MC_addr stable until MC_done.
REQ-020 BUSY, MC_done=1, roll=0: SHALL, in one edge, pulse IF_flag=1, set IF_inst=MC_inst and IF_PC=PC, drop MC_req, return to IDLE.
REQ-021 Prediction: BTB hit = valid && tag==PC[31:BTB_BITS+2] at index PC[BTB_BITS+1:2] && counter[1]; on hit SHALL set IF_BTB_predict=1, IF_BTB_PC=target, PC<=target.
REQ-022 On a BTB miss SHALL set IF_BTB_predict=0, IF_BTB_PC=PC+4, PC<=PC+4; addition is 32-bit with wrap-around.
REQ-023 IF_flag SHALL be high for exactly one enabled cycle per delivered instruction and low otherwise.
REQ-024 Throughput: next request SHALL be issued the edge after the IF_flag edge if IQ_full=0, so one instruction per (memory latency + 1) cycles.
REQ-025 roll in IDLE: SHALL set PC<=roll_PC and issue no request that edge.
REQ-026 roll in BUSY without MC_done: SHALL set PC<=roll_PC, MC_req<=0, go to DRAIN.
REQ-027 roll in BUSY with MC_done: SHALL discard the word (IF_flag=0), set PC<=roll_PC, go to IDLE.
REQ-028 DRAIN: SHALL keep MC_req=0 and ignore the in-flight word; on MC_done go to IDLE; roll in DRAIN SHALL update PC<=roll_PC and stay in DRAIN.
REQ-029 Any roll SHALL force IF_flag=0 at that edge.
REQ-030 rdy=0: SHALL hold all registers and outputs unchanged, including IF_flag and the BTB.
REQ-031 BTB entry: valid, tag, 32-bit target, 2-bit saturating counter.
REQ-032 Update on tag hit: counter SHALL increment on upd_taken (saturating at 3) or decrement on !upd_taken (saturating at 0); target SHALL be overwritten only when taken.
REQ-033 Update on miss with upd_taken: SHALL allocate/replace the entry with valid=1, new tag, target, counter=2.
REQ-034 Update on miss with !upd_taken: SHALL leave the BTB unchanged.
REQ-035 When lookup and update hit the same index in the same cycle, the lookup SHALL see pre-update contents.

Reset
REQ-036 On rst=1, asynchronously: PC=RESET_PC, state=IDLE, MC_req=0, MC_addr=0, IF_flag=0, IF_inst=0, IF_PC=0, IF_BTB_PC=0, IF_BTB_predict=0, all BTB valid=0, all counters=1.
REQ-037 rst asserted mid-BUSY SHALL abandon the request; a MC_done arriving after release in IDLE SHALL be ignored.

Verification
REQ-038 Reset, IQ_full=0, memory latency 3 -> MC_addr 0, 4, 8 in sequence, IF_flag every 4 cycles, IF_BTB_PC=IF_PC+4, predict=0.
REQ-039 IQ_full=1 held for 10 cycles after a delivery -> MC_req stays 0; the next request is issued the edge after IQ_full falls.
REQ-040 roll with roll_PC=0x100 two cycles into BUSY -> state DRAIN, MC_req=0, the late MC_done gives no IF_flag, next MC_addr=0x100.
REQ-041 roll coincident with MC_done -> IF_flag stays 0, next MC_addr=roll_PC.
REQ-042 upd_flag with upd_PC=0x8, upd_target=0x40, upd_taken=1 -> next fetch of 0x8 gives predict=1, IF_BTB_PC=0x40, next MC_addr=0x40; two not-taken updates -> predict=0.
REQ-043 rdy=0 for 5 cycles with IF_flag=1 -> IF_flag and all outputs frozen, then exactly one more pulse cycle after rdy returns.
